// File: rtl/ddr4_cmd_issuer.sv
// DDR4 closed-page command issuer: INIT/CKE bring-up, ACT-RD/WR-PRE per request, periodic REF.
// All pins registered (command visible one cycle after its load edge); stall only blocks command loads.
module ddr4_cmd_issuer #(
  parameter int ADDRWIDTH = 17,
  parameter int BGWIDTH   = 2,
  parameter int BAWIDTH   = 2,
  parameter int COLWIDTH  = 10,
  parameter int TINIT     = 16,
  parameter int TRCD      = 4,
  parameter int TRAS      = 10,
  parameter int TRTP      = 3,
  parameter int TWRP      = 8,
  parameter int TRP       = 4,
  parameter int TRFC      = 20,
  parameter int TREFI     = 200
) (
  input  logic                 ck_tp,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [BGWIDTH-1:0]   req_bg,
  input  logic [BAWIDTH-1:0]   req_ba,
  input  logic [ADDRWIDTH-1:0] req_row,
  input  logic [COLWIDTH-1:0]  req_col,
  input  logic                 stall,
  output logic                 cmd_done,
  output logic                 cke,
  output logic                 cs_n,
  output logic                 act_n,
  output logic [ADDRWIDTH-1:0] addr,
  output logic [BGWIDTH-1:0]   bg,
  output logic [BAWIDTH-1:0]   ba,
  output logic                 parity
);

  localparam int CW = 8;
  localparam int IW = $clog2(TINIT + 1);
  localparam int RW = $clog2(TREFI);
  localparam logic [IW-1:0] INIT_M1  = IW'(TINIT - 1);
  localparam logic [RW-1:0] REFI_M1  = RW'(TREFI - 1);
  localparam logic [CW-1:0] RCD_M1   = CW'(TRCD - 1);
  localparam logic [CW-1:0] RCD_M2   = CW'(TRCD - 2);
  localparam logic [CW-1:0] RAS_M1   = CW'(TRAS - 1);
  localparam logic [CW-1:0] RAS_M2   = CW'(TRAS - 2);
  localparam logic [CW-1:0] RP_M1    = CW'(TRP - 1);
  localparam logic [CW-1:0] RFC_M1   = CW'(TRFC - 1);

  typedef enum logic [3:0] {
    S_INIT, S_IDLE, S_ACT, S_RCD, S_CAS, S_POST, S_PRE, S_RP, S_REF, S_RFC
  } state_t;

  state_t               state;
  logic [IW-1:0]        init_cnt;
  logic [RW-1:0]        ref_cnt;
  logic                 ref_run;
  logic                 ref_pending;
  logic [CW-1:0]        cnt;      // edges since the last command load
  logic [CW-1:0]        ras_cnt;  // edges since the last ACT load
  logic                 l_we;
  logic [BGWIDTH-1:0]   l_bg;
  logic [BAWIDTH-1:0]   l_ba;
  logic [ADDRWIDTH-1:0] l_row;
  logic [COLWIDTH-1:0]  l_col;
  logic [ADDRWIDTH-1:0] cas_addr;
  logic [ADDRWIDTH-1:0] pre_addr;
  logic [ADDRWIDTH-1:0] ref_addr;
  logic [CW-1:0]        wtr_m1;
  logic [CW-1:0]        wtr_m2;
  logic                 ref_expire;

  // A16/A15/A14 carry RAS_n/CAS_n/WE_n on non-ACT commands
  always_comb begin
    cas_addr                 = '0;
    cas_addr[COLWIDTH-1:0]   = l_col;
    cas_addr[12]             = 1'b1;
    cas_addr[14]             = ~l_we;
    cas_addr[16]             = 1'b1;
    pre_addr                 = '0;
    pre_addr[15]             = 1'b1;
    ref_addr                 = '0;
    ref_addr[14]             = 1'b1;
  end

  assign wtr_m1     = l_we ? CW'(TWRP - 1) : CW'(TRTP - 1);
  assign wtr_m2     = l_we ? CW'(TWRP - 2) : CW'(TRTP - 2);
  assign ref_expire = ref_run && (ref_cnt == REFI_M1);

  function automatic logic ca_par(input logic an, input logic [ADDRWIDTH-1:0] a,
                                  input logic [BGWIDTH-1:0] g, input logic [BAWIDTH-1:0] b);
    return ^{an, a, g, b};
  endfunction

  always_ff @(posedge ck_tp) begin
    if (reset) begin
      state       <= S_INIT;
      init_cnt    <= '0;
      ref_cnt     <= '0;
      ref_run     <= 1'b0;
      ref_pending <= 1'b0;
      cnt         <= '0;
      ras_cnt     <= '0;
      l_we        <= 1'b0;
      l_bg        <= '0;
      l_ba        <= '0;
      l_row       <= '0;
      l_col       <= '0;
      req_ready   <= 1'b0;
      cmd_done    <= 1'b0;
      cke         <= 1'b0;
      cs_n        <= 1'b1;
      act_n       <= 1'b1;
      addr        <= '0;
      bg          <= '0;
      ba          <= '0;
      parity      <= 1'b0;
    end else begin
      cs_n     <= 1'b1;
      act_n    <= 1'b1;
      addr     <= '0;
      bg       <= '0;
      ba       <= '0;
      parity   <= 1'b0;
      cmd_done <= 1'b0;
      if (cnt != '1)     cnt     <= cnt + 1'b1;
      if (ras_cnt != '1) ras_cnt <= ras_cnt + 1'b1;
      if (ref_run) begin
        ref_cnt <= ref_expire ? '0 : ref_cnt + 1'b1;
        if (ref_expire) ref_pending <= 1'b1;
      end

      case (state)
        S_INIT: begin
          if (init_cnt == INIT_M1) begin
            cke       <= 1'b1;
            req_ready <= 1'b1;
            ref_run   <= 1'b1;
            ref_cnt   <= '0;
            state     <= S_IDLE;
          end else begin
            init_cnt <= init_cnt + 1'b1;
          end
        end
        S_IDLE: begin
          if (ref_pending) begin
            req_ready <= 1'b0;
            state     <= S_REF;
          end else if (req_valid && req_ready) begin
            l_we      <= req_we;
            l_bg      <= req_bg;
            l_ba      <= req_ba;
            l_row     <= req_row;
            l_col     <= req_col;
            req_ready <= 1'b0;
            state     <= S_ACT;
          end else begin
            req_ready <= ~ref_expire;
          end
        end
        S_ACT: begin
          if (!stall && cnt >= RP_M1) begin
            cs_n    <= 1'b0;
            act_n   <= 1'b0;
            addr    <= l_row;
            bg      <= l_bg;
            ba      <= l_ba;
            parity  <= ca_par(1'b0, l_row, l_bg, l_ba);
            cnt     <= '0;
            ras_cnt <= '0;
            state   <= S_RCD;
          end
        end
        // wait states hand over one edge early so the issue state can load on the first legal edge
        S_RCD: if (cnt >= RCD_M2) state <= S_CAS;
        S_CAS: begin
          if (!stall && cnt >= RCD_M1) begin
            cs_n     <= 1'b0;
            addr     <= cas_addr;
            bg       <= l_bg;
            ba       <= l_ba;
            parity   <= ca_par(1'b1, cas_addr, l_bg, l_ba);
            cmd_done <= 1'b1;
            cnt      <= '0;
            state    <= S_POST;
          end
        end
        S_POST: if (ras_cnt >= RAS_M2 && cnt >= wtr_m2) state <= S_PRE;
        S_PRE: begin
          if (!stall && ras_cnt >= RAS_M1 && cnt >= wtr_m1) begin
            cs_n   <= 1'b0;
            addr   <= pre_addr;
            bg     <= l_bg;
            ba     <= l_ba;
            parity <= ca_par(1'b1, pre_addr, l_bg, l_ba);
            cnt    <= '0;
            state  <= S_RP;
          end
        end
        S_RP: begin
          if (cnt >= RP_M1) begin
            req_ready <= ~(ref_pending | ref_expire);
            state     <= S_IDLE;
          end
        end
        S_REF: begin
          if (!stall && cnt >= RP_M1) begin
            cs_n        <= 1'b0;
            addr        <= ref_addr;
            parity      <= ca_par(1'b1, ref_addr, '0, '0);
            ref_pending <= ref_expire;
            cnt         <= '0;
            state       <= S_RFC;
          end
        end
        S_RFC: begin
          if (cnt >= RFC_M1) begin
            req_ready <= ~(ref_pending | ref_expire);
            state     <= S_IDLE;
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr4_cmd_issuer.sv
// Directed bench for ddr4_cmd_issuer: request vector table plus init, refresh and reset-abort sequences.
module tb_ddr4_cmd_issuer;

  logic        ck_tp = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_bg = '0;
  logic [1:0]  req_ba = '0;
  logic [16:0] req_row = '0;
  logic [9:0]  req_col = '0;
  logic        stall = 1'b0;
  logic        cmd_done, cke, cs_n, act_n, parity;
  logic [16:0] addr;
  logic [1:0]  bg, ba;

  ddr4_cmd_issuer dut (
    .ck_tp(ck_tp), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_bg(req_bg), .req_ba(req_ba), .req_row(req_row), .req_col(req_col),
    .stall(stall), .cmd_done(cmd_done), .cke(cke), .cs_n(cs_n), .act_n(act_n),
    .addr(addr), .bg(bg), .ba(ba), .parity(parity)
  );

  always #5 ck_tp = ~ck_tp;

  int cyc = 0;
  always @(posedge ck_tp) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic        act_n;
    logic [16:0] addr;
    logic [1:0]  bg;
    logic [1:0]  ba;
    logic        par;
    logic        done;
  } ev_t;
  ev_t evq[$];

  always @(negedge ck_tp)
    if (cs_n === 1'b0 || cmd_done === 1'b1)
      evq.push_back('{cyc, act_n, addr, bg, ba, parity, cmd_done});

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic expire(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timed out", nm);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = 1'b0;
    stall     = 1'b0;
    repeat (2) @(negedge ck_tp);
    reset = 1'b0;
  endtask

  task automatic count_init(output int n, output int tup);
    n = 0;
    while (cke !== 1'b1 && n < 100) begin
      n++;
      @(negedge ck_tp);
    end
    tup = cyc;
    if (n >= 100) expire("cke_rise");
  endtask

  task automatic wait_ready(output int t, input int budget, input string nm);
    bit seen = 0;
    t = -1;
    for (int i = 0; i < budget && !seen; i++) begin
      if (req_ready === 1'b1) begin
        seen = 1;
        t = cyc;
      end else begin
        @(negedge ck_tp);
      end
    end
    if (!seen) expire(nm);
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  bg;
    logic [1:0]  ba;
    logic [16:0] row;
    logic [9:0]  col;
    int          stall_n;
    int          act_dly;
    logic        act_par;
    logic [16:0] cas_addr;
    logic        cas_par;
    int          pre_gap;
    logic        pre_par;
  } vec_t;

  vec_t vt[3];

  initial begin
    int n, tup, t0, tacc, t1, tfall, tref;
    bit got_act;

    vt[0] = '{1'b0, 2'd1, 2'd2, 17'h01ABC, 10'h3F0, 0, 1, 1'b0, 17'h153F0, 1'b0, 6, 1'b0};
    vt[1] = '{1'b1, 2'd1, 2'd2, 17'h01ABC, 10'h3F0, 0, 1, 1'b0, 17'h113F0, 1'b1, 8, 1'b0};
    vt[2] = '{1'b0, 2'd2, 2'd1, 17'h00F0E, 10'h001, 5, 6, 1'b1, 17'h15001, 1'b1, 6, 1'b0};

    // reset state and INIT length
    do_reset();
    chk("rst_cke", 32'(cke), 0);
    chk("rst_cs_n", 32'(cs_n), 1);
    chk("rst_act_n", 32'(act_n), 1);
    chk("rst_addr", 32'(addr), 0);
    chk("rst_bg_ba", 32'({bg, ba}), 0);
    chk("rst_parity", 32'(parity), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_cmd_done", 32'(cmd_done), 0);
    count_init(n, tup);
    chk("init_cke_low_cycles", 32'(n), 16);
    chk("init_req_ready", 32'(req_ready), 1);

    foreach (vt[v]) begin
      do_reset();
      count_init(n, tup);
      evq.delete();
      req_we  = vt[v].we;
      req_bg  = vt[v].bg;
      req_ba  = vt[v].ba;
      req_row = vt[v].row;
      req_col = vt[v].col;
      req_valid = 1'b1;
      wait_ready(t0, 10, $sformatf("v%0d_accept", v));
      tacc = t0 + 1;
      @(negedge ck_tp);
      req_valid = 1'b0;
      if (vt[v].stall_n > 0) stall = 1'b1;
      repeat (vt[v].stall_n) @(negedge ck_tp);
      stall = 1'b0;
      wait_ready(t1, 60, $sformatf("v%0d_ready_back", v));
      @(negedge ck_tp);
      chk($sformatf("v%0d_cmd_count", v), 32'(evq.size()), 3);
      if (evq.size() >= 3) begin
        chk($sformatf("v%0d_act_time", v), 32'(evq[0].cyc - tacc), 32'(vt[v].act_dly));
        chk($sformatf("v%0d_act_n", v), 32'(evq[0].act_n), 0);
        chk($sformatf("v%0d_act_addr", v), 32'(evq[0].addr), 32'(vt[v].row));
        chk($sformatf("v%0d_act_bgba", v), 32'({evq[0].bg, evq[0].ba}), 32'({vt[v].bg, vt[v].ba}));
        chk($sformatf("v%0d_act_par", v), 32'(evq[0].par), 32'(vt[v].act_par));
        chk($sformatf("v%0d_act_done", v), 32'(evq[0].done), 0);
        chk($sformatf("v%0d_rcd_gap", v), 32'(evq[1].cyc - evq[0].cyc), 4);
        chk($sformatf("v%0d_cas_act_n", v), 32'(evq[1].act_n), 1);
        chk($sformatf("v%0d_cas_addr", v), 32'(evq[1].addr), 32'(vt[v].cas_addr));
        chk($sformatf("v%0d_cas_bgba", v), 32'({evq[1].bg, evq[1].ba}), 32'({vt[v].bg, vt[v].ba}));
        chk($sformatf("v%0d_cas_par", v), 32'(evq[1].par), 32'(vt[v].cas_par));
        chk($sformatf("v%0d_cas_done", v), 32'(evq[1].done), 1);
        chk($sformatf("v%0d_pre_gap", v), 32'(evq[2].cyc - evq[1].cyc), 32'(vt[v].pre_gap));
        chk($sformatf("v%0d_pre_addr", v), 32'(evq[2].addr), 32'h08000);
        chk($sformatf("v%0d_pre_par", v), 32'(evq[2].par), 32'(vt[v].pre_par));
        chk($sformatf("v%0d_pre_done", v), 32'(evq[2].done), 0);
        chk($sformatf("v%0d_rp_ready_gap", v), 32'(t1 - evq[2].cyc), 4);
      end
    end

    // refresh expiry in IDLE takes priority over a pending request
    do_reset();
    count_init(n, tup);
    evq.delete();
    tfall = -1;
    for (int i = 0; i < 400 && tfall < 0; i++) begin
      if (req_ready !== 1'b1) tfall = cyc;
      else @(negedge ck_tp);
    end
    if (tfall < 0) expire("ref_ready_drop");
    chk("ref_interval", 32'(tfall - tup), 200);
    req_we = 1'b0; req_bg = 2'd3; req_ba = 2'd0; req_row = 17'h00055; req_col = 10'h010;
    req_valid = 1'b1;
    wait_ready(t1, 60, "ref_ready_back");
    @(negedge ck_tp);
    req_valid = 1'b0;
    repeat (3) @(negedge ck_tp);
    chk("ref_cmd_count", 32'(evq.size()), 2);
    if (evq.size() >= 2) begin
      tref = evq[0].cyc;
      chk("ref_time", 32'(tref - tfall), 2);
      chk("ref_addr", 32'(evq[0].addr), 32'h04000);
      chk("ref_act_n", 32'(evq[0].act_n), 1);
      chk("ref_bgba", 32'({evq[0].bg, evq[0].ba}), 0);
      chk("ref_par", 32'(evq[0].par), 0);
      chk("ref_rfc_ready_gap", 32'(t1 - tref), 20);
      chk("ref_then_act_time", 32'(evq[1].cyc - t1), 2);
      chk("ref_then_act_addr", 32'(evq[1].addr), 32'h00055);
      chk("ref_then_act_n", 32'(evq[1].act_n), 0);
    end

    // reset while waiting in RCD aborts without RD or PRE
    do_reset();
    count_init(n, tup);
    evq.delete();
    req_we = 1'b0; req_bg = 2'd1; req_ba = 2'd2; req_row = 17'h01ABC; req_col = 10'h3F0;
    req_valid = 1'b1;
    wait_ready(t0, 10, "abort_accept");
    @(negedge ck_tp);
    req_valid = 1'b0;
    got_act = 0;
    for (int i = 0; i < 10 && !got_act; i++) begin
      if (cs_n === 1'b0) got_act = 1;
      else @(negedge ck_tp);
    end
    if (!got_act) expire("abort_act_wait");
    chk("abort_act_seen", 32'(act_n), 0);
    reset = 1'b1;
    @(negedge ck_tp);
    reset = 1'b0;
    chk("abort_cs_n", 32'(cs_n), 1);
    chk("abort_cke", 32'(cke), 0);
    chk("abort_req_ready", 32'(req_ready), 0);
    count_init(n, tup);
    chk("abort_init_cycles", 32'(n), 16);
    repeat (4) @(negedge ck_tp);
    chk("abort_no_rd_pre", 32'(evq.size()), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
